// File: rtl/fxp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fxp_pkg
//  Description : Shared fixed-point definitions for the RMSNorm datapath.
//                FXP_N / FXP_R give the default data width and fractional
//                bits. Also holds the RMS controller state type and an
//                unsigned saturation helper.
//  Revision    : 1.0  initial release
// ============================================================================
package fxp_pkg;

    localparam int FXP_N = 16;
    localparam int FXP_R = 8;

    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        REQ   = 2'd1,
        WAIT  = 2'd2,
        OUT   = 2'd3
    } rms_state_t;

    // Clamp an unsigned value to the largest number representable in
    // 'width' bits.
    function automatic logic [63:0] fxp_sat_u(input logic [63:0] value, input int width);
        logic [63:0] max_v;
        max_v = (width >= 64) ? {64{1'b1}} : ((64'd1 << width) - 64'd1);
        return (value > max_v) ? max_v : value;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fxp_sqrt.sv
`default_nettype none
// ============================================================================
//  Module      : fxp_sqrt
//  Description : Iterative unsigned fixed-point square root, one result bit
//                per cycle. root = floor(sqrt(rad * 2^FBITS)), so an
//                unsigned Q.FBITS radicand gives an unsigned Q.FBITS root.
//                valid clears on the start edge and is held once the root is
//                ready; busy is high while iterating.
//  Ports       : clk, reset_n (async, active-low)
//                start  in   request, ignored while busy
//                rad    in   WIDTH radicand
//                busy   out  iteration in progress
//                valid  out  root valid
//                root   out  WIDTH root
//  Revision    : 1.0  initial release
// ============================================================================
module fxp_sqrt
    import fxp_pkg::*;
#(
    parameter int WIDTH = FXP_N,
    parameter int FBITS = FXP_R
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] rad,
    output logic             busy,
    output logic             valid,
    output logic [WIDTH-1:0] root
);

    localparam int ITER  = (WIDTH + FBITS + 1) / 2;
    localparam int XW    = 2 * ITER;
    localparam int REM_W = ITER + 3;
    localparam int CNT_W = $clog2(ITER + 1);

    logic [XW-1:0]    x_q;
    logic [REM_W-1:0] rem_q;
    logic [ITER-1:0]  root_q;
    logic [CNT_W-1:0] cnt_q;
    logic             busy_q;
    logic             valid_q;

    logic [REM_W-1:0] w_rem_t;
    logic [REM_W-1:0] w_trial;
    logic             w_ge;

    // Restoring square root: bring down two radicand bits, try root*4+1.
    assign w_rem_t = (rem_q << 2) | REM_W'(x_q[XW-1:XW-2]);
    assign w_trial = REM_W'({root_q, 2'b01});
    assign w_ge    = (w_rem_t >= w_trial);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            x_q     <= '0;
            rem_q   <= '0;
            root_q  <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
        end else if (start && !busy_q) begin
            x_q     <= XW'(rad) << FBITS;
            rem_q   <= '0;
            root_q  <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            valid_q <= 1'b0;
        end else if (busy_q) begin
            x_q    <= x_q << 2;
            rem_q  <= w_ge ? (w_rem_t - w_trial) : w_rem_t;
            root_q <= {root_q[ITER-2:0], w_ge};
            cnt_q  <= cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(ITER - 1)) begin
                busy_q  <= 1'b0;
                valid_q <= 1'b1;
            end
        end
    end

    assign busy  = busy_q;
    assign valid = valid_q;
    assign root  = WIDTH'(root_q);

endmodule
`default_nettype wire

// File: rtl/fxp_rms_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : fxp_rms_ctrl
//  Description : RMSNorm front end. Accumulates x^2 over LEN signed
//                activations, forms mean(x^2)+EPS (saturated to WIDTH bits),
//                requests one root from an external, shareable fxp_sqrt and
//                presents the RMS on a valid/ready output.
//  Ports       : clk, reset_n (async, active-low)
//                in_valid/in_ready/in_data     activation stream (signed)
//                sqrt_start/sqrt_rad           request to fxp_sqrt
//                sqrt_busy/sqrt_valid/sqrt_root  fxp_sqrt status and result
//                rms_valid/rms_ready/rms/rms_sat result (unsigned Q.FBITS)
//  Revision    : 1.0  initial release
// ============================================================================
module fxp_rms_ctrl
    import fxp_pkg::*;
#(
    parameter int WIDTH = FXP_N,
    parameter int FBITS = FXP_R,
    parameter int LEN   = 256,
    parameter int EPS   = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             sqrt_start,
    output logic [WIDTH-1:0] sqrt_rad,
    input  logic             sqrt_busy,
    input  logic             sqrt_valid,
    input  logic [WIDTH-1:0] sqrt_root,
    output logic             rms_valid,
    input  logic             rms_ready,
    output logic [WIDTH-1:0] rms,
    output logic             rms_sat
);

    localparam int LOG2LEN = $clog2(LEN);
    localparam int ACC_W   = 2 * WIDTH - FBITS + LOG2LEN;

    localparam logic [1:0] ST_ACCUM = ACCUM;
    localparam logic [1:0] ST_REQ   = REQ;
    localparam logic [1:0] ST_WAIT  = WAIT;
    localparam logic [1:0] ST_OUT   = OUT;

    logic [1:0]         state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [LOG2LEN-1:0] cnt_q, cnt_d;
    logic               sat_q, sat_d;
    logic [WIDTH-1:0]   rms_q, rms_d;
    logic               rms_sat_q, rms_sat_d;

    logic signed [2*WIDTH-1:0] w_sq;
    logic [ACC_W-1:0]          w_sq_sh;
    logic [ACC_W:0]            w_mean_eps;
    logic                      w_sat;
    logic [WIDTH-1:0]          w_rad;

    // The square is never negative, so the arithmetic shift is a plain
    // truncation of the fractional bits.
    assign w_sq    = $signed(in_data) * $signed(in_data);
    assign w_sq_sh = ACC_W'($unsigned(w_sq >>> FBITS));

    // LEN is a power of two: the mean is a right shift of the sum.
    assign w_mean_eps = {1'b0, acc_q >> LOG2LEN} + (ACC_W + 1)'(EPS);
    assign w_sat      = |w_mean_eps[ACC_W:WIDTH];
    assign w_rad      = WIDTH'(fxp_sat_u(64'(w_mean_eps), WIDTH));

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        sat_d     = sat_q;
        rms_d     = rms_q;
        rms_sat_d = rms_sat_q;
        case (state_q)
            ST_ACCUM: begin
                if (in_valid) begin
                    acc_d = acc_q + w_sq_sh;
                    cnt_d = cnt_q + LOG2LEN'(1);
                    if (cnt_q == LOG2LEN'(LEN - 1)) begin
                        state_d = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                // The engine may be serving another client; hold until idle.
                if (!sqrt_busy) begin
                    sat_d   = w_sat;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (sqrt_valid && !sqrt_busy) begin
                    rms_d     = sqrt_root;
                    rms_sat_d = sat_q;
                    state_d   = ST_OUT;
                end
            end
            ST_OUT: begin
                if (rms_ready) begin
                    acc_d   = '0;
                    state_d = ST_ACCUM;
                end
            end
            default: begin
                state_d = ST_ACCUM;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_ACCUM;
            acc_q     <= '0;
            cnt_q     <= '0;
            sat_q     <= 1'b0;
            rms_q     <= '0;
            rms_sat_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            sat_q     <= sat_d;
            rms_q     <= rms_d;
            rms_sat_q <= rms_sat_d;
        end
    end

    assign in_ready   = (state_q == ST_ACCUM);
    assign sqrt_start = (state_q == ST_REQ) && !sqrt_busy;
    assign sqrt_rad   = (state_q == ST_REQ) ? w_rad : '0;
    assign rms_valid  = (state_q == ST_OUT);
    assign rms        = rms_q;
    assign rms_sat    = rms_sat_q;

endmodule
`default_nettype wire
